// File: rtl/fix_frame_checker.sv
// Streaming FIX frame checker: walks "8=..|9=len|35=x..|10=ddd|" byte by byte,
// verifies BodyLength, the 35= lead-in and the mod-256 checksum, then pulses done or error.
module fix_frame_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  message_i,
  input  logic        valid_i,
  output logic        message_received_o,
  output logic        error_o,
  output logic [7:0]  msg_type_o,
  output logic [15:0] body_len_o,
  output logic [7:0]  checksum_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, BEGIN, LEN, BODY, TRAIL, CSUM} state_t;

  localparam logic [7:0] SOH = 8'h01;

  state_t      state_q, state_n;
  logic [2:0]  pos_q, pos_n;      // sub-position within a field, or digit count + 2 in LEN
  logic [16:0] len_q, len_n;
  logic [9:0]  ck_q, ck_n;
  logic [15:0] cnt_q, cnt_n;
  logic [7:0]  sum_q, sum_n;
  logic [7:0]  pend_q, pend_n;
  logic        good, bad;

  logic [7:0]  b;
  logic        is_dig;
  logic [16:0] len_calc;
  logic [9:0]  ck_calc;
  logic [7:0]  sum_add;
  logic [15:0] cnt_inc;

  assign b        = message_i;
  assign is_dig   = (b >= "0") && (b <= "9");
  assign len_calc = len_q * 17'd10 + {13'd0, b[3:0]};
  assign ck_calc  = ck_q * 10'd10 + {6'd0, b[3:0]};
  assign sum_add  = sum_q + b;
  assign cnt_inc  = cnt_q + 16'd1;

  always_comb begin
    state_n = state_q;
    pos_n   = pos_q;
    len_n   = len_q;
    ck_n    = ck_q;
    cnt_n   = cnt_q;
    sum_n   = sum_q;
    pend_n  = pend_q;
    good    = 1'b0;
    bad     = 1'b0;
    if (valid_i) begin
      case (state_q)
        IDLE: if (b == "8") begin
          state_n = BEGIN;
          pos_n   = 3'd0;
          sum_n   = b;
          len_n   = 17'd0;
          cnt_n   = 16'd0;
          ck_n    = 10'd0;
        end
        BEGIN: begin
          sum_n = sum_add;
          if (pos_q == 3'd0) begin
            if (b != "=") bad = 1'b1;
            else pos_n = 3'd1;
          end else if (b == SOH) begin
            state_n = LEN;
            pos_n   = 3'd0;
          end
        end
        LEN: begin
          sum_n = sum_add;
          if (pos_q == 3'd0) begin
            if (b != "9") bad = 1'b1;
            else pos_n = 3'd1;
          end else if (pos_q == 3'd1) begin
            if (b != "=") bad = 1'b1;
            else pos_n = 3'd2;
          end else if (is_dig) begin
            if (pos_q == 3'd7 || len_calc > 17'd65535) bad = 1'b1;
            else begin
              len_n = len_calc;
              pos_n = pos_q + 3'd1;
            end
          end else if (b == SOH) begin
            // no digits, or a zero length (body must hold tag 35)
            if (pos_q == 3'd2 || len_q == 17'd0) bad = 1'b1;
            else begin
              state_n = BODY;
              cnt_n   = 16'd0;
            end
          end else bad = 1'b1;
        end
        BODY: begin
          sum_n = sum_add;
          cnt_n = cnt_inc;
          if ((cnt_q == 16'd0 && b != "3") || (cnt_q == 16'd1 && b != "5") ||
              (cnt_q == 16'd2 && b != "="))
            bad = 1'b1;
          else if (cnt_inc == len_q[15:0]) begin
            // last body byte: must be SOH and the msg-type byte must already be in
            if (b != SOH || cnt_q < 16'd4) bad = 1'b1;
            else begin
              state_n = TRAIL;
              pos_n   = 3'd0;
            end
          end else if (cnt_q == 16'd3) pend_n = b;
        end
        TRAIL: begin
          if ((pos_q == 3'd0 && b != "1") || (pos_q == 3'd1 && b != "0") ||
              (pos_q == 3'd2 && b != "="))
            bad = 1'b1;
          else if (pos_q == 3'd2) begin
            state_n = CSUM;
            pos_n   = 3'd0;
            ck_n    = 10'd0;
          end else pos_n = pos_q + 3'd1;
        end
        CSUM: begin
          if (is_dig) begin
            if (pos_q == 3'd3) bad = 1'b1;
            else begin
              ck_n  = ck_calc;
              pos_n = pos_q + 3'd1;
            end
          end else if (b == SOH && pos_q == 3'd3) begin
            if (ck_q > 10'd255 || ck_q[7:0] != sum_q) bad = 1'b1;
            else good = 1'b1;
          end else bad = 1'b1;
        end
        default: bad = 1'b1;
      endcase
    end
    if (good || bad) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      pos_q              <= 3'd0;
      len_q              <= 17'd0;
      ck_q               <= 10'd0;
      cnt_q              <= 16'd0;
      sum_q              <= 8'd0;
      pend_q             <= 8'd0;
      message_received_o <= 1'b0;
      error_o            <= 1'b0;
      msg_type_o         <= 8'd0;
      body_len_o         <= 16'd0;
      checksum_o         <= 8'd0;
    end else begin
      state_q            <= state_n;
      pos_q              <= pos_n;
      len_q              <= len_n;
      ck_q               <= ck_n;
      cnt_q              <= cnt_n;
      sum_q              <= sum_n;
      pend_q             <= pend_n;
      message_received_o <= good;
      error_o            <= bad;
      if (good) begin
        msg_type_o <= pend_q;
        body_len_o <= len_q[15:0];
        checksum_o <= sum_q;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: doc/fix_frame_checker.md
FIX_FRAME_CHECKER -- requirements
Module: fix_frame_checker

Interface
REQ-001 The block SHALL have one clock, `clk`; every state element SHALL update on its rising edge.
REQ-002 Reset SHALL be input `rst`, asynchronous and active-low.
REQ-003 `message_i` SHALL be an input, 8 bits: one byte of the outbound FIX stream.
REQ-004 `valid_i` SHALL be an input, 1 bit: `message_i` is valid this cycle; every valid byte SHALL be accepted, with no backpressure.
REQ-005 `message_received_o` SHALL be an output, 1 bit: one-cycle pulse when a well-formed frame completes.
REQ-006 `error_o` SHALL be an output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-007 `msg_type_o` SHALL be an output, 8 bits: first value byte of tag 35 in the last good frame.
REQ-008 `body_len_o` SHALL be an output, 16 bits: BodyLength (tag 9) of the last good frame.
REQ-009 `checksum_o` SHALL be an output, 8 bits: computed checksum of the last good frame.
REQ-010 `busy_o` SHALL be an output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The frame format SHALL be "8=<ver>SOH9=<len>SOH<body>10=<ddd>SOH", with SOH = 0x01; only cycles with `valid_i`=1 SHALL advance the parser.
REQ-012 The FSM SHALL have the states IDLE, BEGIN, LEN, BODY, TRAIL and CSUM.
- IDLE: discard bytes until '8'.
- BEGIN: the next byte must be '='; then accept any bytes until SOH.
- LEN: expect "9=", then 1-5 ASCII digits, then SOH.
- BODY: count exactly <len> bytes.
- TRAIL: expect "10=".
- CSUM: expect exactly 3 digits, then SOH.
REQ-013 The running sum SHALL be an 8-bit modulo-256 accumulator covering every byte from the leading '8' through the last body byte inclusive.
REQ-014 The length value SHALL be accumulated as value*10+digit in 17 bits; a value above 65535, a sixth digit, zero digits, or a non-digit SHALL be an error.
REQ-015 BodyLength 0 SHALL be an error, because the body must contain tag 35.
REQ-016 The first body bytes SHALL be "35="; any mismatch SHALL be an error.
- The byte after "35=" is captured as the pending msg_type.
- If the body ends before that byte arrives, it SHALL be an error.
REQ-017 When the body count reaches <len>, the block SHALL enter TRAIL; the last body byte SHALL be SOH, otherwise error.
REQ-018 The received checksum SHALL be computed as d2*100+d1*10+d0 in 10 bits; a value above 255, or a mismatch with the running sum, SHALL be an error.
REQ-019 On the terminating SOH of a good frame, the next cycle SHALL:
- pulse `message_received_o` for 1 cycle;
- update `msg_type_o`, `body_len_o` and `checksum_o` together;
- return the FSM to IDLE.
REQ-020 On any error, the next cycle SHALL pulse `error_o` for 1 cycle and return to IDLE; the outputs SHALL keep their last good values. The error byte SHALL be consumed and SHALL NOT restart a frame.
REQ-021 `valid_i`=0 gaps of any length anywhere in a frame SHALL leave the state, counters and sum unchanged.
REQ-022 `message_received_o` and `error_o` SHALL never be high in the same cycle.

Reset
REQ-023 While `rst`=0, the following SHALL hold regardless of `clk`:
- state = IDLE;
- `message_received_o`, `error_o` and `busy_o` = 0;
- `msg_type_o` = 0x00, `body_len_o` = 0, `checksum_o` = 0;
- all counters and accumulators = 0.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame with no pulse; parsing SHALL resume from IDLE on the first `clk` edge after `rst` returns to 1.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Good frame: "8=FIX.4.2|9=5|35=0|10=161|" (| = 0x01), sent back-to-back -> exactly 1 `message_received_o` pulse, the cycle after the final SOH; `msg_type_o`=0x30, `body_len_o`=5, `checksum_o`=0xA1, `error_o` stays 0.
- Same frame with random `valid_i` gaps of 0-3 cycles -> identical result and pulse count.
- Checksum field "10=162" -> `error_o` pulses once; `message_received_o` stays 0; outputs keep their prior values.
- Length digits "9=1234567" -> `error_o` on the 6th digit; the following good frame is accepted with `body_len_o`=5.
- `rst` driven low in BODY, then the good frame resent -> no pulse during reset; after reset, 1 `message_received_o` pulse.
- Garbage bytes 0x41 0x01 0x3D before the good frame -> ignored in IDLE; 1 pulse, 0 errors.
